// File: rtl/cnn_pkg.sv
// Shared CNN definitions: data word width, buffer FSM state type and the
// bit-width helper used to size index ports.
package cnn_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } buf_state_t;

  // Number of bits needed to represent value (at least 1), so an index port
  // can also carry the first out-of-range value.
  function automatic int logb2(input int value);
    int n;
    n = 1;
    for (int i = 0; i < 31; i++) begin
      if ((value >> i) != 0) begin
        n = i + 1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/pool_map_ram.sv
// Pooled-map storage: one row-wide write port, one word-wide combinational
// read port. Word 0 of a row sits in the MSBs of wr_data.
module pool_map_ram
  import cnn_pkg::*;
#(
  parameter int ROW_WORDS = 3,
  parameter int DEPTH     = 12,
  parameter int SW        = 4,
  parameter int CW        = 2
) (
  input  logic                            clk,
  input  logic                            wr_en,
  input  logic [SW-1:0]                   wr_slot,
  input  logic [ROW_WORDS*DATA_WIDTH-1:0] wr_data,
  input  logic [SW-1:0]                   rd_slot,
  input  logic [CW-1:0]                   rd_col,
  output logic [DATA_WIDTH-1:0]           rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH][ROW_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < ROW_WORDS; c++) begin
        mem[wr_slot][c] <= wr_data[(ROW_WORDS-1-c)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rd_data = mem[rd_slot][rd_col];

endmodule

// File: rtl/pool_map_buffer.sv
// Collects pooled rows of TOTAL_FEATURE maps into a slot bitmap-tracked RAM,
// then streams every word out feature-major, row, col with valid/ready.
module pool_map_buffer
  import cnn_pkg::*;
#(
  parameter int OUTPUT_SIZE   = 3,
  parameter int KERNEL_SIZE   = 2,
  parameter int TOTAL_FEATURE = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  input  logic [logb2(TOTAL_FEATURE)-1:0]                in_feature_idx,
  input  logic [logb2(OUTPUT_SIZE*KERNEL_SIZE)-1:0]      in_feature_row,
  input  logic [OUTPUT_SIZE*DATA_WIDTH-1:0]              in_data,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic [DATA_WIDTH-1:0]                          out_data,
  output logic [logb2(TOTAL_FEATURE)-1:0]                out_feature,
  output logic [logb2(OUTPUT_SIZE)-1:0]                  out_row,
  output logic [logb2(OUTPUT_SIZE)-1:0]                  out_col,
  output logic                                           out_last,
  output logic                                           err_range,
  output logic                                           err_overflow
);

  localparam int FW    = logb2(TOTAL_FEATURE);
  localparam int CW    = logb2(OUTPUT_SIZE);
  localparam int SLOTS = TOTAL_FEATURE * OUTPUT_SIZE;
  localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  buf_state_t             state;
  logic [SLOTS-1:0]       bitmap;
  logic [SLOTS-1:0]       bitmap_set;
  logic [FW-1:0]          feat_cnt;
  logic [CW-1:0]          row_cnt;
  logic [CW-1:0]          col_cnt;
  logic [DATA_WIDTH-1:0]  rd_data;
  logic [SW-1:0]          wr_slot;
  logic [SW-1:0]          rd_slot;
  logic                   in_range;
  logic                   wr_en;
  logic                   last_word;
  int                     in_prow;

  assign in_prow    = int'(in_feature_row) / KERNEL_SIZE;
  assign in_range   = (int'(in_feature_idx) < TOTAL_FEATURE) && (in_prow < OUTPUT_SIZE);
  assign in_ready   = (state == FILL);
  assign wr_en      = in_valid && in_ready && in_range;
  assign wr_slot    = SW'(int'(in_feature_idx) * OUTPUT_SIZE + in_prow);
  assign bitmap_set = bitmap | (SLOTS'(1) << wr_slot);
  assign rd_slot    = SW'(int'(feat_cnt) * OUTPUT_SIZE + int'(row_cnt));
  assign last_word  = (feat_cnt == FW'(TOTAL_FEATURE - 1)) &&
                      (row_cnt == CW'(OUTPUT_SIZE - 1)) &&
                      (col_cnt == CW'(OUTPUT_SIZE - 1));

  // Counters sit at zero outside DRAIN, so the coordinates read 0 in FILL.
  assign out_valid   = (state == DRAIN);
  assign out_last    = out_valid && last_word;
  assign out_data    = out_valid ? rd_data : '0;
  assign out_feature = feat_cnt;
  assign out_row     = row_cnt;
  assign out_col     = col_cnt;

  pool_map_ram #(
    .ROW_WORDS (OUTPUT_SIZE),
    .DEPTH     (SLOTS),
    .SW        (SW),
    .CW        (CW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_slot (wr_slot),
    .wr_data (in_data),
    .rd_slot (rd_slot),
    .rd_col  (col_cnt),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= FILL;
      bitmap       <= '0;
      feat_cnt     <= '0;
      row_cnt      <= '0;
      col_cnt      <= '0;
      err_range    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (in_valid && !in_ready) begin
        err_overflow <= 1'b1;
      end
      if (in_valid && in_ready && !in_range) begin
        err_range <= 1'b1;
      end
      case (state)
        FILL: begin
          if (wr_en) begin
            bitmap <= bitmap_set;
            if (&bitmap_set) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (last_word) begin
              bitmap   <= '0;
              feat_cnt <= '0;
              row_cnt  <= '0;
              col_cnt  <= '0;
              state    <= FILL;
            end else if (col_cnt != CW'(OUTPUT_SIZE - 1)) begin
              col_cnt <= col_cnt + 1'b1;
            end else if (row_cnt != CW'(OUTPUT_SIZE - 1)) begin
              col_cnt <= '0;
              row_cnt <= row_cnt + 1'b1;
            end else begin
              col_cnt  <= '0;
              row_cnt  <= '0;
              feat_cnt <= feat_cnt + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_map_buffer.sv
// Scoreboard bench for pool_map_buffer at default parameters (3x3 maps,
// stride 2, 4 features).
module tb_pool_map_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_feature_idx;
  logic [2:0]  in_feature_row;
  logic [95:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [2:0]  out_feature;
  logic [1:0]  out_row;
  logic [1:0]  out_col;
  logic        out_last;
  logic        err_range;
  logic        err_overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  f;
    logic [1:0]  r;
    logic [1:0]  c;
    logic        l;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [4][3][3];

  pool_map_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_feature_idx (in_feature_idx),
    .in_feature_row (in_feature_row),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_feature    (out_feature),
    .out_row        (out_row),
    .out_col        (out_col),
    .out_last       (out_last),
    .err_range      (err_range),
    .err_overflow   (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic beat(input int f, input int row, input logic [95:0] d);
    in_valid       = 1'b1;
    in_feature_idx = 3'(f);
    in_feature_row = 3'(row);
    in_data        = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Distinct float-like pattern per fill/feature/row/col; updates the model.
  task automatic put_row(input int f, input int row, input int seed);
    logic [95:0] d;
    logic [31:0] w;
    for (int c = 0; c < 3; c++) begin
      w = 32'h3F00_0000 | 32'((seed & 255) << 12) | 32'(f << 8) | 32'((row / 2) << 4) | 32'(c);
      d[(2-c)*32 +: 32] = w;
      model[f][row/2][c] = w;
    end
    beat(f, row, d);
  endtask

  task automatic push_expected();
    exp_t e;
    for (int f = 0; f < 4; f++)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) begin
          e.d = model[f][r][c];
          e.f = 3'(f);
          e.r = 2'(r);
          e.c = 2'(c);
          e.l = (f == 3 && r == 2 && c == 2);
          sb.push_back(e);
        end
  endtask

  task automatic fill_order(input int ord[12], input int seed, input bit odd_rows);
    for (int i = 0; i < 12; i++) begin
      if (i == 11) begin
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL pre_complete out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
        end
      end
      put_row(ord[i] / 3, (ord[i] % 3) * 2 + (odd_rows ? 1 : 0), seed);
    end
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_start out_valid=%b in_ready=%b required 1/0", out_valid, in_ready);
    end
    push_expected();
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic drain(input int mode, input string name);
    int k;
    exp_t e;
    k = 0;
    while (sb.size() > 0 && k < 400) begin
      out_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      e = sb[0];
      checks++;
      if (out_valid !== 1'b1 || {out_data, out_feature, out_row, out_col, out_last} !== e) begin
        errors++;
        $display("FAIL %s word v=%b d=%h f=%0d r=%0d c=%0d l=%b required d=%h f=%0d r=%0d c=%0d l=%b",
                 name, out_valid, out_data, out_feature, out_row, out_col, out_last,
                 e.d, e.f, e.r, e.c, e.l);
      end
      if (out_ready) void'(sb.pop_front());
      @(posedge clk); #1;
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s timeout remaining=%0d required 0", name, sb.size());
      sb.delete();
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s post_last in_ready=%b out_valid=%b required 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_feature_idx = '0; in_feature_row = '0;
    in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_last, err_range, err_overflow, out_data, out_feature, out_row, out_col} !== '0
        || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset v=%b l=%b er=%b eo=%b d=%h ready=%b required zeros ready=1",
               out_valid, out_last, err_range, err_overflow, out_data, in_ready);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int ord[12];
    for (int i = 0; i < 12; i++) ord[i] = i;
    out_ready = 1'b1;
    fill_order(ord, 1, 1'b0);
    drain(0, "basic");
  endtask

  task automatic test_shuffle();
    int ord[12];
    int sh[12] = '{7, 2, 11, 0, 5, 9, 3, 10, 1, 8, 6, 4};
    for (int i = 0; i < 12; i++) ord[i] = 11 - i;
    fill_order(ord, 2, 1'b1);
    drain(0, "reverse");
    fill_order(sh, 2, 1'b0);
    drain(0, "shuffle");
  endtask

  task automatic test_rewrite();
    int others[10] = '{0, 1, 2, 3, 5, 6, 7, 8, 9, 10};
    beat(1, 2, {3{32'h3F80_0000}});
    for (int i = 0; i < 10; i++) put_row(others[i] / 3, (others[i] % 3) * 2, 3);
    beat(1, 2, {3{32'h4000_0000}});
    for (int c = 0; c < 3; c++) model[1][1][c] = 32'h4000_0000;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL rewrite_early v=%b ready=%b er=%b required 0/1/0", out_valid, in_ready, err_range);
    end
    put_row(3, 4, 3);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rewrite_complete out_valid=%b required 1", out_valid);
    end
    push_expected();
    drain(0, "rewrite");
  endtask

  task automatic test_stall();
    int ord[12];
    for (int i = 0; i < 12; i++) ord[i] = (i * 5) % 12;
    fill_order(ord, 4, 1'b0);
    drain(1, "stall");
  endtask

  task automatic test_errors();
    int ord[12];
    for (int i = 0; i < 12; i++) ord[i] = i;
    for (int i = 0; i < 6; i++) put_row(ord[i] / 3, (ord[i] % 3) * 2, 5);
    beat(4, 0, {3{32'hDEAD_BEEF}});
    checks++;
    if (err_range !== 1'b1 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL range_feature er=%b eo=%b required 1/0", err_range, err_overflow);
    end
    beat(0, 6, {3{32'hDEAD_BEEF}});
    for (int i = 6; i < 11; i++) put_row(ord[i] / 3, (ord[i] % 3) * 2, 5);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL range_bitmap out_valid=%b required 0", out_valid);
    end
    put_row(3, 4, 5);
    push_expected();
    out_ready = 1'b0;
    beat(0, 0, {3{32'hBAD0_BAD0}});
    checks++;
    if (err_overflow !== 1'b1 || err_range !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL overflow eo=%b er=%b v=%b required 1/1/1", err_overflow, err_range, out_valid);
    end
    drain(0, "overflow");
  endtask

  task automatic test_reset_mid();
    int ord[12];
    for (int i = 0; i < 12; i++) ord[i] = i;
    fill_order(ord, 6, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      void'(sb.pop_front());
      @(posedge clk); #1;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== model[1][0][1]) begin
      errors++;
      $display("FAIL pre_rst word10 v=%b d=%h required 1/%h", out_valid, out_data, model[1][0][1]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 ||
        err_range !== 1'b0 || err_overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst v=%b ready=%b d=%h er=%b eo=%b required 0/1/0/0/0",
               out_valid, in_ready, out_data, err_range, err_overflow);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fill_order(ord, 7, 1'b1);
    drain(0, "after_rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_shuffle();
    test_rewrite();
    test_stall();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
